// File: rtl/hist_pkg.sv
// Shared constants, readout FSM states and line-buffer address packing for the
// histogram statistics / readout pair.
package hist_pkg;

   localparam int BINS    = 128;
   localparam int CNT_W   = 16;
   localparam int BLK_W   = 4;
   localparam int SRAM_AW = 9;
   localparam int REG_AW  = 10;
   localparam int BIN_W   = 7;
   localparam int PAIR_W  = 6;
   localparam int NBLK_W  = 5;
   localparam int BYTE_W  = 8;
   localparam int MAX_BLK = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_B,
      ST_OUT_E,
      ST_OUT_O
   } rd_state_t;

   // Block pairs share one SRAM/regfile pair; blk[0] is carried on the toggle line.
   function automatic logic [SRAM_AW-1:0] sram_addr_pack(
      input logic [BLK_W-2:0]  blk_hi,
      input logic [PAIR_W-1:0] pair
   );
      return {blk_hi, pair};
   endfunction

   function automatic logic [REG_AW-1:0] reg_addr_pack(
      input logic [BLK_W-2:0] blk_hi,
      input logic [BIN_W-1:0] bin
   );
      return {blk_hi, bin};
   endfunction

endpackage

// File: rtl/hist_rd_addr_gen.sv
// Block / bin-pair walker for the histogram readout: holds the clamped block
// count for the pass and flags the final pair of the final block.
module hist_rd_addr_gen
   import hist_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [NBLK_W-1:0] i_nblk,
   input  logic              i_adv,
   output logic [BLK_W-1:0]  o_blk,
   output logic [PAIR_W-1:0] o_pair,
   output logic              o_last_pair
);

   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(BINS / 2 - 1);

   logic [NBLK_W-1:0] r_nblk;
   logic [BLK_W-1:0]  r_blk;
   logic [PAIR_W-1:0] r_pair;
   logic              w_pair_wrap;
   logic              w_last_blk;

   assign w_pair_wrap = (r_pair == LAST_PAIR);
   assign w_last_blk  = ({1'b0, r_blk} == (r_nblk - 1'b1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nblk <= '0;
         r_blk  <= '0;
         r_pair <= '0;
      end else if (i_load) begin
         r_nblk <= i_nblk;
         r_blk  <= '0;
         r_pair <= '0;
      end else if (i_adv) begin
         if (w_pair_wrap) begin
            r_pair <= '0;
            r_blk  <= r_blk + 1'b1;
         end else begin
            r_pair <= r_pair + 1'b1;
         end
      end
   end

   assign o_blk       = r_blk;
   assign o_pair      = r_pair;
   assign o_last_pair = w_pair_wrap & w_last_blk;

endmodule

// File: rtl/hist_readout.sv
// Read-and-clear engine: walks every bin pair of each block, merges SRAM high
// byte with regfile low byte and streams 16-bit counts over valid/ready.
module hist_readout
   import hist_pkg::*;
(
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               line_sel_i,
   input  logic [NBLK_W-1:0]  block_num_h_i,
   input  logic               clr_en_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               mem_toggle_o,
   output logic               sram_toggle_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic               sram_cen_o,
   output logic               sram_wen_o,
   output logic [CNT_W-1:0]   sram_wdata_o,
   input  logic [CNT_W-1:0]   sram_rdata_i,
   output logic               reg_toggle_o,
   output logic [REG_AW-1:0]  reg_addr_rd_o,
   output logic               reg_rd_en_o,
   output logic [REG_AW-1:0]  reg_addr_wr_o,
   output logic               reg_wr_en_o,
   output logic [BYTE_W-1:0]  reg_wdata_o,
   input  logic [BYTE_W-1:0]  reg_rdata_i,
   output logic               hist_valid_o,
   input  logic               hist_ready_i,
   output logic [CNT_W-1:0]   hist_data_o,
   output logic [BIN_W-1:0]   hist_bin_o,
   output logic [BLK_W-1:0]   hist_block_o,
   output logic               hist_last_o
);

   function automatic logic [NBLK_W-1:0] sat_nblk(input logic [NBLK_W-1:0] n);
      return (n > NBLK_W'(MAX_BLK)) ? NBLK_W'(MAX_BLK) : n;
   endfunction

   rd_state_t r_state;
   rd_state_t w_next;

   logic              r_line_sel;
   logic              r_clr_en;
   logic              r_done;
   logic              r_lo_o_pend;
   logic [BYTE_W-1:0] r_hi_e;
   logic [BYTE_W-1:0] r_hi_o;
   logic [BYTE_W-1:0] r_lo_e;
   logic [BYTE_W-1:0] r_lo_o;

   logic [BLK_W-1:0]  w_blk;
   logic [PAIR_W-1:0] w_pair;
   logic              w_last_pair;
   logic [BIN_W-1:0]  w_bin_e;
   logic [BIN_W-1:0]  w_bin_o;
   logic              w_start_ok;
   logic              w_n_zero;
   logic              w_hs_o;
   logic              w_fin;
   logic              w_adv;

   assign w_bin_e    = {w_pair, 1'b0};
   assign w_bin_o    = {w_pair, 1'b1};
   assign w_n_zero   = (block_num_h_i == '0);
   assign w_start_ok = start_i & ~abort_i & (r_state == ST_IDLE);
   assign w_hs_o     = (r_state == ST_OUT_O) & hist_ready_i;
   assign w_fin      = w_hs_o & w_last_pair & ~abort_i;
   assign w_adv      = w_hs_o & ~w_last_pair & ~abort_i;

   hist_rd_addr_gen u_addr_gen (
      .clk         (pclk),
      .rst_n       (rst_n),
      .i_load      (w_start_ok),
      .i_nblk      (sat_nblk(block_num_h_i)),
      .i_adv       (w_adv),
      .o_blk       (w_blk),
      .o_pair      (w_pair),
      .o_last_pair (w_last_pair)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      sram_cen_o    = 1'b1;
      sram_wen_o    = 1'b1;
      sram_addr_o   = '0;
      reg_rd_en_o   = 1'b0;
      reg_addr_rd_o = '0;
      reg_wr_en_o   = 1'b0;
      reg_addr_wr_o = '0;
      hist_valid_o  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok && !w_n_zero) w_next = ST_RD_A;
         end
         ST_RD_A: begin
            sram_cen_o    = 1'b0;
            sram_addr_o   = sram_addr_pack(w_blk[BLK_W-1:1], w_pair);
            reg_rd_en_o   = 1'b1;
            reg_addr_rd_o = reg_addr_pack(w_blk[BLK_W-1:1], w_bin_e);
            w_next        = ST_RD_B;
         end
         ST_RD_B: begin
            reg_rd_en_o   = 1'b1;
            reg_addr_rd_o = reg_addr_pack(w_blk[BLK_W-1:1], w_bin_o);
            w_next        = ST_OUT_E;
         end
         ST_OUT_E: begin
            hist_valid_o = 1'b1;
            // One SRAM word clears both high bytes; the odd one is already captured.
            if (r_clr_en) begin
               sram_cen_o    = 1'b0;
               sram_wen_o    = 1'b0;
               sram_addr_o   = sram_addr_pack(w_blk[BLK_W-1:1], w_pair);
               reg_wr_en_o   = 1'b1;
               reg_addr_wr_o = reg_addr_pack(w_blk[BLK_W-1:1], w_bin_e);
            end
            if (hist_ready_i) w_next = ST_OUT_O;
         end
         ST_OUT_O: begin
            hist_valid_o = 1'b1;
            if (r_clr_en) begin
               reg_wr_en_o   = 1'b1;
               reg_addr_wr_o = reg_addr_pack(w_blk[BLK_W-1:1], w_bin_o);
            end
            if (hist_ready_i) w_next = w_last_pair ? ST_IDLE : ST_RD_A;
         end
         default: w_next = ST_IDLE;
      endcase
      if (abort_i) w_next = ST_IDLE;
   end

   // Capture stage: SRAM word and lo(2p) arrive in RD_B, lo(2p+1) one cycle later.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_sel  <= 1'b0;
         r_clr_en    <= 1'b0;
         r_done      <= 1'b0;
         r_lo_o_pend <= 1'b0;
         r_hi_e      <= '0;
         r_hi_o      <= '0;
         r_lo_e      <= '0;
         r_lo_o      <= '0;
      end else begin
         r_done      <= w_fin | (w_start_ok & w_n_zero);
         r_lo_o_pend <= (r_state == ST_RD_B);
         if (w_start_ok) begin
            r_line_sel <= line_sel_i;
            r_clr_en   <= clr_en_i;
         end
         if (r_state == ST_RD_B) begin
            r_hi_e <= sram_rdata_i[BYTE_W-1:0];
            r_hi_o <= sram_rdata_i[CNT_W-1:BYTE_W];
            r_lo_e <= reg_rdata_i;
         end
         if (r_lo_o_pend) r_lo_o <= reg_rdata_i;
      end
   end

   assign busy_o        = (r_state != ST_IDLE);
   assign done_o        = r_done;
   assign mem_toggle_o  = r_line_sel;
   assign sram_toggle_o = w_blk[0];
   assign reg_toggle_o  = w_blk[0];
   assign sram_wdata_o  = '0;
   assign reg_wdata_o   = '0;
   assign hist_data_o   = (r_state == ST_OUT_O) ? {r_hi_o, r_lo_o} : {r_hi_e, r_lo_e};
   assign hist_bin_o    = (r_state == ST_OUT_O) ? w_bin_o : w_bin_e;
   assign hist_block_o  = w_blk;
   assign hist_last_o   = w_last_pair & (r_state == ST_OUT_O);

endmodule

// File: tb/tb_hist_readout.sv
// Directed bench for hist_readout with SRAM/regfile line-buffer models.
module tb_hist_readout;
   import hist_pkg::*;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        line_sel_i = 1'b0;
   logic [4:0]  block_num_h_i = '0;
   logic        clr_en_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        hist_ready_i = 1'b1;
   logic [15:0] sram_rdata_i = '0;
   logic [7:0]  reg_rdata_i = '0;
   logic        busy_o, done_o, mem_toggle_o, sram_toggle_o, reg_toggle_o;
   logic [8:0]  sram_addr_o;
   logic        sram_cen_o, sram_wen_o;
   logic [15:0] sram_wdata_o;
   logic [9:0]  reg_addr_rd_o, reg_addr_wr_o;
   logic        reg_rd_en_o, reg_wr_en_o;
   logic [7:0]  reg_wdata_o;
   logic        hist_valid_o, hist_last_o;
   logic [15:0] hist_data_o;
   logic [6:0]  hist_bin_o;
   logic [3:0]  hist_block_o;

   always #5 pclk = ~pclk;

   hist_readout dut (
      .pclk(pclk), .rst_n(rst_n), .start_i(start_i), .line_sel_i(line_sel_i),
      .block_num_h_i(block_num_h_i), .clr_en_i(clr_en_i), .abort_i(abort_i),
      .busy_o(busy_o), .done_o(done_o), .mem_toggle_o(mem_toggle_o),
      .sram_toggle_o(sram_toggle_o), .sram_addr_o(sram_addr_o), .sram_cen_o(sram_cen_o),
      .sram_wen_o(sram_wen_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
      .reg_toggle_o(reg_toggle_o), .reg_addr_rd_o(reg_addr_rd_o), .reg_rd_en_o(reg_rd_en_o),
      .reg_addr_wr_o(reg_addr_wr_o), .reg_wr_en_o(reg_wr_en_o), .reg_wdata_o(reg_wdata_o),
      .reg_rdata_i(reg_rdata_i), .hist_valid_o(hist_valid_o), .hist_ready_i(hist_ready_i),
      .hist_data_o(hist_data_o), .hist_bin_o(hist_bin_o), .hist_block_o(hist_block_o),
      .hist_last_o(hist_last_o)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Mode 0: only line0 blk0 bin5 = 0x1234; mode 1: distinct value per bin.
   function automatic logic [15:0] pat(input int mode, input logic line, input int blk, input int bin);
      if (mode == 0) return (!line && blk == 0 && bin == 5) ? 16'h1234 : 16'h0000;
      return 16'(int'(line) * 32768 + blk * 2065 + bin * 259 + 33);
   endfunction
   function automatic logic [7:0] hi_of(input int mode, input logic line, input int blk, input int bin);
      logic [15:0] w;
      w = pat(mode, line, blk, bin);
      return w[15:8];
   endfunction
   function automatic logic [7:0] lo_of(input int mode, input logic line, input int blk, input int bin);
      logic [15:0] w;
      w = pat(mode, line, blk, bin);
      return w[7:0];
   endfunction

   // Memory models: [line][toggle][addr], synchronous read.
   logic [15:0] sram_m [2][2][512];
   logic [7:0]  reg_m  [2][2][1024];
   logic        pl_req = 1'b0;
   logic        pl_line = 1'b0;
   int          pl_mode = 0;

   always @(posedge pclk) begin
      if (pl_req) begin
         for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 128; k++) begin
               sram_m[pl_line][1'(b)][9'((b / 2) * 64 + k / 2)][(k % 2) * 8 +: 8] <= hi_of(pl_mode, pl_line, b, k);
               reg_m[pl_line][1'(b)][10'((b / 2) * 128 + k)] <= lo_of(pl_mode, pl_line, b, k);
            end
         end
      end else begin
         if (!sram_cen_o) begin
            if (sram_wen_o) sram_rdata_i <= sram_m[mem_toggle_o][sram_toggle_o][sram_addr_o];
            else sram_m[mem_toggle_o][sram_toggle_o][sram_addr_o] <= sram_wdata_o;
         end
         if (reg_rd_en_o) reg_rdata_i <= reg_m[mem_toggle_o][reg_toggle_o][reg_addr_rd_o];
         if (reg_wr_en_o) reg_m[mem_toggle_o][reg_toggle_o][reg_addr_wr_o] <= reg_wdata_o;
      end
   end

   typedef struct packed {
      logic [3:0]  blk;
      logic [6:0]  bin;
      logic [15:0] data;
      logic        last;
   } beat_t;

   beat_t       beats[$];
   logic        mon_clr = 1'b0;
   int          cyc, busy_cnt, done_cnt, done_cyc, last_cyc, cen_cnt, rstb_cnt, stall_err, tog_err;
   logic        stalled, pab, pl;
   logic [15:0] pd;
   logic [6:0]  pb;
   logic [3:0]  pk;
   logic [8:0]  cap_sram;
   logic [9:0]  cap_reg;

   always @(negedge pclk) begin
      if (mon_clr) begin
         beats.delete();
         cyc <= 0; busy_cnt <= 0; done_cnt <= 0; done_cyc <= -1; last_cyc <= -10;
         cen_cnt <= 0; rstb_cnt <= 0; stall_err <= 0; tog_err <= 0;
         stalled <= 1'b0; pab <= 1'b0; cap_sram <= '0; cap_reg <= '0;
      end else begin
         cyc <= cyc + 1;
         if (busy_o) busy_cnt <= busy_cnt + 1;
         if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (!sram_cen_o) cen_cnt <= cen_cnt + 1;
         if (reg_rd_en_o || reg_wr_en_o) rstb_cnt <= rstb_cnt + 1;
         if (hist_valid_o && (sram_toggle_o !== hist_block_o[0] || reg_toggle_o !== hist_block_o[0]))
            tog_err <= tog_err + 1;
         if (stalled && !pab &&
             (!hist_valid_o || hist_data_o !== pd || hist_bin_o !== pb || hist_block_o !== pk || hist_last_o !== pl))
            stall_err <= stall_err + 1;
         stalled <= hist_valid_o & ~hist_ready_i;
         pab <= abort_i;
         pd <= hist_data_o; pb <= hist_bin_o; pk <= hist_block_o; pl <= hist_last_o;
         if (hist_valid_o && hist_ready_i) begin
            beats.push_back('{hist_block_o, hist_bin_o, hist_data_o, hist_last_o});
            if (hist_last_o) last_cyc <= cyc;
         end
         if (!sram_cen_o && sram_wen_o && hist_block_o == 4'd5 && hist_bin_o[6:1] == 6'd38)
            cap_sram <= sram_addr_o;
         if (reg_rd_en_o && reg_addr_rd_o[0] && hist_block_o == 4'd5 && hist_bin_o[6:1] == 6'd38)
            cap_reg <= reg_addr_rd_o;
      end
   end

   task automatic preload(input logic line, input int mode);
      @(posedge pclk); #1;
      pl_req = 1'b1; pl_line = line; pl_mode = mode;
      @(posedge pclk); #1;
      pl_req = 1'b0;
   endtask

   task automatic do_start(input logic ln, input logic [4:0] n, input logic clr);
      @(posedge pclk); #1;
      mon_clr = 1'b1;
      @(posedge pclk); #1;
      mon_clr = 1'b0;
      line_sel_i = ln; block_num_h_i = n; clr_en_i = clr; start_i = 1'b1;
      @(posedge pclk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         hist_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(posedge pclk); #1;
         if (done_o) begin
            ok = 1'b1;
            break;
         end
      end
      hist_ready_i = 1'b1;
   endtask

   task automatic settle();
      repeat (2) @(posedge pclk);
      #1;
   endtask

   task automatic seq_check(input logic line, input int n, input int mode, output int mis);
      mis = 0;
      for (int i = 0; i < beats.size(); i++) begin
         if (beats[i].blk !== 4'(i / 128) || beats[i].bin !== 7'(i % 128) ||
             beats[i].data !== pat(mode, line, i / 128, i % 128) || beats[i].last !== (i == n * 128 - 1))
            mis++;
      end
   endtask

   // Compares stored bytes against zero or against the preloaded pattern.
   task automatic mem_diff(input logic line, input int nblk, input bit want_zero, output int nd);
      logic [15:0] w;
      logic [7:0]  hb, lb, eh, el;
      nd = 0;
      for (int b = 0; b < nblk; b++) begin
         for (int k = 0; k < 128; k++) begin
            w  = sram_m[line][1'(b)][9'((b / 2) * 64 + k / 2)];
            hb = (k % 2 != 0) ? w[15:8] : w[7:0];
            lb = reg_m[line][1'(b)][10'((b / 2) * 128 + k)];
            eh = want_zero ? 8'h00 : hi_of(1, line, b, k);
            el = want_zero ? 8'h00 : lo_of(1, line, b, k);
            if (hb !== eh || lb !== el) nd++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit found;
      int mis, nd;

      // Reset state
      repeat (3) @(posedge pclk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_valid", hist_valid_o, 0);
      check("rst_cen", sram_cen_o, 1);
      check("rst_wen", sram_wen_o, 1);
      check("rst_strobes", {reg_rd_en_o, reg_wr_en_o}, 0);
      check("rst_addr", {sram_addr_o, reg_addr_rd_o, reg_addr_wr_o}, 0);
      check("rst_data", hist_data_o, 0);
      rst_n = 1'b1;

      // 1: single block, bin5 = 0x1234, timing
      preload(1'b0, 0);
      do_start(1'b0, 5'd1, 1'b0);
      wait_done(2000, 1'b0, ok);
      check("t1_done_seen", 32'(ok), 1);
      settle();
      check("t1_beats", beats.size(), 128);
      check("t1_bin5", beats[5].data, 16'h1234);
      check("t1_last127", {beats[127].bin, beats[127].last}, {7'd127, 1'b1});
      seq_check(1'b0, 1, 0, mis);
      check("t1_seq", mis, 0);
      check("t1_cycles", busy_cnt, 256);
      check("t1_done_after_last", done_cyc - last_cyc, 1);
      check("t1_done_pulses", done_cnt, 1);
      check("t1_done_low", done_o, 0);

      // 2: clear pass over a 10-block line
      preload(1'b0, 1);
      do_start(1'b0, 5'd10, 1'b1);
      wait_done(6000, 1'b0, ok);
      check("t2_done_seen", 32'(ok), 1);
      settle();
      check("t2_beats", beats.size(), 1280);
      seq_check(1'b0, 10, 1, mis);
      check("t2_seq", mis, 0);
      check("t2_cycles", busy_cnt, 2560);
      mem_diff(1'b0, 10, 1'b1, nd);
      check("t2_cleared", nd, 0);

      // 3 + 6: backpressure, line 1, no clear, address spot check
      preload(1'b1, 1);
      do_start(1'b1, 5'd6, 1'b0);
      wait_done(20000, 1'b1, ok);
      check("t3_done_seen", 32'(ok), 1);
      settle();
      check("t3_beats", beats.size(), 768);
      seq_check(1'b1, 6, 1, mis);
      check("t3_seq", mis, 0);
      check("t3_stall_stable", stall_err, 0);
      check("t3_toggle", tog_err, 0);
      mem_diff(1'b1, 6, 1'b0, nd);
      check("t3_unchanged", nd, 0);
      check("t6_mem_toggle", mem_toggle_o, 1);
      check("t6_sram_addr", cap_sram, 9'h0A6);
      check("t6_reg_addr", cap_reg, {3'd2, 7'd77});
      check("t3_done_pulses", done_cnt, 1);

      // 4: N == 0
      do_start(1'b0, 5'd0, 1'b0);
      check("t4_done", done_o, 1);
      check("t4_busy", busy_o, 0);
      @(posedge pclk); #1;
      check("t4_done_pulse", done_o, 0);
      settle();
      check("t4_no_cen", cen_cnt, 0);
      check("t4_no_reg", rstb_cnt, 0);

      // 5: abort in OUT_E of blk3 bin40
      preload(1'b0, 1);
      do_start(1'b0, 5'd5, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge pclk); #1;
         if (hist_valid_o && hist_block_o == 4'd3 && hist_bin_o == 7'd40) begin
            found = 1'b1;
            break;
         end
      end
      check("t5_reached", 32'(found), 1);
      hist_ready_i = 1'b0;
      abort_i = 1'b1;
      @(posedge pclk); #1;
      abort_i = 1'b0;
      hist_ready_i = 1'b1;
      check("t5_valid", hist_valid_o, 0);
      check("t5_busy", busy_o, 0);
      check("t5_done", done_o, 0);
      repeat (4) @(posedge pclk);
      #1;
      check("t5_no_done", done_cnt, 0);
      check("t5_beats", beats.size(), 424);

      // 5b: fresh run with a start pulse while busy
      preload(1'b0, 1);
      do_start(1'b0, 5'd1, 1'b0);
      wait_done(50, 1'b0, ok);
      start_i = 1'b1; line_sel_i = 1'b1; block_num_h_i = 5'd5;
      @(posedge pclk); #1;
      start_i = 1'b0;
      wait_done(2000, 1'b0, ok);
      check("t5b_done_seen", 32'(ok), 1);
      settle();
      check("t5b_beats", beats.size(), 128);
      seq_check(1'b0, 1, 1, mis);
      check("t5b_seq", mis, 0);
      check("t5b_mem_toggle", mem_toggle_o, 0);
      check("t5b_cycles", busy_cnt, 256);
      check("t5b_done_pulses", done_cnt, 1);

      // N > 16 is clamped
      preload(1'b1, 1);
      do_start(1'b1, 5'd20, 1'b0);
      wait_done(6000, 1'b0, ok);
      check("clamp_done_seen", 32'(ok), 1);
      settle();
      check("clamp_beats", beats.size(), 2048);
      seq_check(1'b1, 16, 1, mis);
      check("clamp_seq", mis, 0);

      // Asynchronous reset mid-run
      preload(1'b0, 1);
      do_start(1'b0, 5'd2, 1'b0);
      repeat (10) @(posedge pclk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", hist_valid_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_cen", sram_cen_o, 1);
      check("arst_reg", {reg_rd_en_o, reg_wr_en_o}, 0);
      @(posedge pclk); #1;
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
